sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider.sv | 128 ++++++++++++
 tb/tb_sequential_divider.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module   : sequential_divider
//  Purpose  : 8-bit unsigned restoring divider. Performs one quotient bit per
//             clock, so a division takes 8 calculation cycles. A zero divisor
//             completes at once with quotient 8'hFF, remainder = dividend and
//             divByZero set.
//  Ports    : clk        - rising-edge clock for all state
//             rst        - asynchronous active-high reset
//             start      - division request, accepted only in IDLE or DONE
//             operandA   - unsigned dividend, latched on an accepted start
//             operandB   - unsigned divisor, latched on an accepted start
//             quotient   - registered quotient of the last completed division
//             remainder  - registered remainder of the last completed division
//             divByZero  - registered flag, last completed divisor was zero
//             busy       - high while a division is in progress
//             done       - one-cycle pulse marking valid results
//  Revision : 1.0  initial release
// ============================================================================
module sequential_divider (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] operandA,
   input  logic [7:0] operandB,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       divByZero,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state_q;
   logic [8:0] prem_q;     // partial remainder
   logic [7:0] dvd_q;      // dividend, shifted out MSB-first; quotient shifts in
   logic [7:0] dvs_q;      // latched divisor
   logic [3:0] cnt_q;      // completed restoring steps
   logic [7:0] quo_q;
   logic [7:0] rmd_q;
   logic       dbz_q;
   logic       busy_q;
   logic       done_q;

   // One restoring step
   logic [8:0] shift_d;
   logic       ge_d;
   logic [8:0] diff_d;
   logic [8:0] prem_d;
   logic [7:0] dvd_d;

   always_comb begin
      shift_d = {prem_q[7:0], dvd_q[7]};
      // prem_q[8] set would mean the true shifted value exceeds any divisor.
      // It never happens because the remainder stays below the divisor, but
      // folding it in keeps the comparison exact for a full 9-bit remainder.
      ge_d    = prem_q[8] | (shift_d >= {1'b0, dvs_q});
      diff_d  = shift_d - {1'b0, dvs_q};
      prem_d  = ge_d ? diff_d : shift_d;
      dvd_d   = {dvd_q[6:0], ge_d};
   end

   // busy and done are registered from the state, so they trail it by one
   // cycle: busy covers the 8 edges after acceptance and done follows the
   // edge that loaded the results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         prem_q  <= 9'd0;
         dvd_q   <= 8'd0;
         dvs_q   <= 8'd0;
         cnt_q   <= 4'd0;
         quo_q   <= 8'd0;
         rmd_q   <= 8'd0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         busy_q <= (state_q == S_CALC);
         done_q <= (state_q == S_DONE);
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  dvd_q  <= operandA;
                  dvs_q  <= operandB;
                  prem_q <= 9'd0;
                  cnt_q  <= 4'd0;
                  if (operandB == 8'd0) begin
                     quo_q   <= 8'hFF;
                     rmd_q   <= operandA;
                     dbz_q   <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_CALC;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CALC: begin
               prem_q <= prem_d;
               dvd_q  <= dvd_d;
               cnt_q  <= cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  quo_q   <= dvd_d;
                  rmd_q   <= prem_d[7:0];
                  dbz_q   <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign quotient  = quo_q;
   assign remainder = rmd_q;
   assign divByZero = dbz_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sequential_divider
//  Purpose  : Scoreboard testbench for sequential_divider. Expected results
//             are queued when a start is driven and compared on each done
//             pulse, together with latency and busy-cycle count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sequential_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] operandA;
   logic [7:0] operandB;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       divByZero;
   logic       busy;
   logic       done;

   sequential_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .operandA  (operandA),
      .operandB  (operandB),
      .quotient  (quotient),
      .remainder (remainder),
      .divByZero (divByZero),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         acc;   // cycle number of the accepting edge
      int         lat;   // edges from acceptance to done
      int         bsy;   // busy cycles expected before done
   } exp_t;

   exp_t       sb[$];
   int         checks   = 0;
   int         errors   = 0;
   int         cyc      = 0;
   int         busy_cnt = 0;
   logic [7:0] last_q   = 8'd0;
   logic [7:0] last_r   = 8'd0;
   logic       last_dz  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input int acc);
      exp_t e;
      e.dz  = (b == 8'd0);
      e.q   = e.dz ? 8'hFF : a / b;
      e.r   = e.dz ? a : a % b;
      e.acc = acc;
      e.lat = e.dz ? 1 : 9;
      e.bsy = e.dz ? 0 : 8;
      sb.push_back(e);
   endtask

   // Output monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
      end else if (done) begin
         check("done_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("quotient", {24'd0, quotient}, {24'd0, e.q});
            check("remainder", {24'd0, remainder}, {24'd0, e.r});
            check("divByZero", {31'd0, divByZero}, {31'd0, e.dz});
            check("latency", cyc - e.acc, e.lat);
            check("busy_cycles", busy_cnt, e.bsy);
            check("busy_with_done", {31'd0, busy}, 32'd0);
            last_q  = e.q;
            last_r  = e.r;
            last_dz = e.dz;
         end
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt++;
      end
   end

   task automatic do_start(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      operandA = a;
      operandB = b;
      start    = 1'b1;
      push_exp(a, b, cyc + 1);
      @(negedge clk);
      start    = 1'b0;
      operandA = 8'($urandom);
      operandB = 8'($urandom);
   endtask

   task automatic wait_empty(input int bound);
      int n = 0;
      while (sb.size() != 0 && n < bound) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("sb_drained", sb.size(), 0);
      repeat (2) @(negedge clk);
      check("hold_quotient", {24'd0, quotient}, {24'd0, last_q});
      check("hold_remainder", {24'd0, remainder}, {24'd0, last_r});
      check("hold_divByZero", {31'd0, divByZero}, {31'd0, last_dz});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_quotient"}, {24'd0, quotient}, 32'd0);
      check({tag, "_remainder"}, {24'd0, remainder}, 32'd0);
      check({tag, "_divByZero"}, {31'd0, divByZero}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int acc0;
      rst      = 1'b1;
      start    = 1'b0;
      operandA = 8'd0;
      operandB = 8'd0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      do_start(8'd200, 8'd7);
      wait_empty(30);
      do_start(8'd25, 8'd31);
      wait_empty(30);
      do_start(8'd255, 8'd1);
      wait_empty(30);

      do_start(8'd42, 8'd0);
      wait_empty(30);
      do_start(8'd170, 8'd85);
      wait_empty(30);

      // Start while busy must be ignored and not queued
      do_start(8'd100, 8'd9);
      @(negedge clk);
      operandA = 8'd50;
      operandB = 8'd0;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_empty(30);
      repeat (12) @(negedge clk);
      check("ignored_start_busy", {31'd0, busy}, 32'd0);

      // Reset in the middle of a calculation
      do_start(8'd200, 8'd7);
      repeat (3) @(posedge clk);
      #2;
      rst   = 1'b1;
      start = 1'b1;
      #1;
      check_all_zero("midreset");
      sb.delete();
      last_q  = 8'd0;
      last_r  = 8'd0;
      last_dz = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("inreset");
      rst   = 1'b0;
      start = 1'b0;
      repeat (12) @(negedge clk);
      check("post_reset_busy", {31'd0, busy}, 32'd0);
      check("post_reset_quotient", {24'd0, quotient}, 32'd0);
      do_start(8'd15, 8'd1);
      wait_empty(30);

      // Start held high: back-to-back operations every 9 cycles
      @(negedge clk);
      operandA = 8'd8;
      operandB = 8'd3;
      start    = 1'b1;
      acc0     = cyc + 1;
      push_exp(8'd8, 8'd3, acc0);
      push_exp(8'd8, 8'd3, acc0 + 9);
      push_exp(8'd8, 8'd3, acc0 + 18);
      while (cyc < acc0 + 18) @(negedge clk);
      start = 1'b0;
      wait_empty(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
